mem_access_stage: RTL and testbench

MEM pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register. It consumes the EX/MEM outputs, performs word, halfword and byte loads and stores over a variable-latency req/ack data-memory port, and stalls upstream while an access is outstanding. It resolves conditional branches and delivers registered writeback data to the WB stage.

---
 rtl/mem_access_stage_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and bundles for the MEM access stage
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        DT_WORD  = 2'b00,
        DT_HALF  = 2'b01,
        DT_BYTE  = 2'b10,
        DT_UBYTE = 2'b11
    } dt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] readdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } wb_t;

    // Instruction context captured at issue so the retire path does not depend on EX/MEM holding.
    typedef struct packed {
        dt_t         dt;
        logic [1:0]  lo;
        logic        regwrite;
        logic        memtoreg;
        logic        store;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ctx_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian store lane placement and load lane extraction/extension
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  dt_t         dt,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [15:0] lane_h;
    logic [7:0]  lane_b;

    always_comb begin
        be         = 4'b1111;
        st_word    = st_data;
        ld_data    = ld_word;
        misaligned = 1'b0;
        lane_h     = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        lane_b     = ld_word[{addr_lo, 3'b000} +: 8];
        case (dt)
            DT_WORD: begin
                misaligned = |addr_lo;
            end
            DT_HALF: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_word    = {2{st_data[15:0]}};
                ld_data    = {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                be      = 4'b0001 << addr_lo;
                st_word = {4{st_data[7:0]}};
                ld_data = (dt == DT_UBYTE) ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: req/ack data-memory access, branch resolve, WB register
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        In_Valid,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_Zero,
    input  logic [1:0]  MEM_Datatype,
    input  logic [31:0] MEM_PCResult,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_Data2,
    input  logic [4:0]  MEM_RegDstData,
    output logic        Stall,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [29:0] Mem_Addr,
    output logic [3:0]  Mem_Be,
    output logic [31:0] Mem_WData,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        WB_Valid,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg,
    output logic [31:0] WB_ReadData,
    output logic [31:0] WB_ALUResult,
    output logic [4:0]  WB_RegDstData,
    output logic        Br_Taken,
    output logic [31:0] Br_Target,
    output logic        Align_Err,
    output logic        Timeout_Err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    ctx_t           ctx_q, ctx_d;
    mem_req_t       mreq_q, mreq_d;
    wb_t            wb_q, wb_d;
    logic           br_taken_q, br_taken_d;
    logic [31:0]    br_target_q, br_target_d;
    logic           align_err_q, align_err_d;
    logic           timeout_err_q, timeout_err_d;

    logic           mem_op, tmo_hit, misaligned;
    dt_t            sel_dt;
    logic [1:0]     sel_lo;
    logic [3:0]     be;
    logic [31:0]    st_word, ld_data;

    assign mem_op  = MEM_MemRead | MEM_MemWrite;
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = (cnt_inc == TIMEOUT_C);
    assign sel_dt  = (state_q == ST_WAIT) ? ctx_q.dt : dt_t'(MEM_Datatype);
    assign sel_lo  = (state_q == ST_WAIT) ? ctx_q.lo : MEM_ALUResult[1:0];

    mem_lane_align u_lane (
        .dt         (sel_dt),
        .addr_lo    (sel_lo),
        .st_data    (MEM_Data2),
        .ld_word    (Mem_RData),
        .be         (be),
        .st_word    (st_word),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ctx_q         <= '0;
            mreq_q        <= '0;
            wb_q          <= '0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ctx_q         <= ctx_d;
            mreq_q        <= mreq_d;
            wb_q          <= wb_d;
            br_taken_q    <= br_taken_d;
            br_target_q   <= br_target_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ctx_d         = ctx_q;
        mreq_d        = mreq_q;
        wb_d          = wb_q;
        wb_d.valid    = 1'b0;
        br_taken_d    = 1'b0;
        br_target_d   = br_target_q;
        align_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (In_Valid && mem_op && !misaligned) begin
                    // A set MemWrite wins over MemRead: the access is a store.
                    mreq_d = '{req: 1'b1, we: MEM_MemWrite, addr: MEM_ALUResult[31:2],
                               be: MEM_MemWrite ? be : 4'b1111, wdata: st_word};
                    ctx_d  = '{dt: dt_t'(MEM_Datatype), lo: MEM_ALUResult[1:0],
                               regwrite: MEM_RegWrite, memtoreg: MEM_MemtoReg,
                               store: MEM_MemWrite, alu: MEM_ALUResult, rd: MEM_RegDstData};
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else if (In_Valid) begin
                    wb_d = '{valid: 1'b1, regwrite: MEM_RegWrite & ~mem_op, memtoreg: MEM_MemtoReg,
                             readdata: '0, alu: MEM_ALUResult, rd: MEM_RegDstData};
                    align_err_d = mem_op;
                    br_taken_d  = MEM_Branch & MEM_Zero;
                    br_target_d = MEM_PCResult;
                end
            end
            ST_WAIT: begin
                if (Mem_Ack) begin
                    mreq_d.req = 1'b0;
                    wb_d = '{valid: 1'b1, regwrite: ctx_q.regwrite & ~ctx_q.store,
                             memtoreg: ctx_q.memtoreg, readdata: ctx_q.store ? '0 : ld_data,
                             alu: ctx_q.alu, rd: ctx_q.rd};
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    mreq_d.req = 1'b0;
                    wb_d = '{valid: 1'b1, regwrite: 1'b0, memtoreg: ctx_q.memtoreg,
                             readdata: '0, alu: ctx_q.alu, rd: ctx_q.rd};
                    timeout_err_d = 1'b1;
                    cnt_d         = cnt_inc;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The aborting cycle also releases upstream so the failed instruction retires instead of reissuing.
    always_comb begin
        Stall = 1'b0;
        case (state_q)
            ST_IDLE: Stall = In_Valid & mem_op & ~misaligned;
            ST_WAIT: Stall = ~(Mem_Ack | tmo_hit);
            default: Stall = 1'b0;
        endcase
    end

    assign Mem_Req       = mreq_q.req;
    assign Mem_We        = mreq_q.we;
    assign Mem_Addr      = mreq_q.addr;
    assign Mem_Be        = mreq_q.be;
    assign Mem_WData     = mreq_q.wdata;
    assign WB_Valid      = wb_q.valid;
    assign WB_RegWrite   = wb_q.regwrite;
    assign WB_MemtoReg   = wb_q.memtoreg;
    assign WB_ReadData   = wb_q.readdata;
    assign WB_ALUResult  = wb_q.alu;
    assign WB_RegDstData = wb_q.rd;
    assign Br_Taken      = br_taken_q;
    assign Br_Target     = br_target_q;
    assign Align_Err     = align_err_q;
    assign Timeout_Err   = timeout_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Clr, In_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite;
    logic        MEM_Branch, MEM_Zero;
    logic [1:0]  MEM_Datatype;
    logic [31:0] MEM_PCResult, MEM_ALUResult, MEM_Data2;
    logic [4:0]  MEM_RegDstData;
    logic        Stall, Mem_Req, Mem_We, Mem_Ack;
    logic [29:0] Mem_Addr;
    logic [3:0]  Mem_Be;
    logic [31:0] Mem_WData, Mem_RData;
    logic        WB_Valid, WB_RegWrite, WB_MemtoReg, Br_Taken, Align_Err, Timeout_Err;
    logic [31:0] WB_ReadData, WB_ALUResult, Br_Target;
    logic [4:0]  WB_RegDstData;

    always #5 Clk = ~Clk;

    mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .Clk(Clk), .Clr(Clr), .In_Valid(In_Valid),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_Datatype(MEM_Datatype),
        .MEM_PCResult(MEM_PCResult), .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
        .MEM_RegDstData(MEM_RegDstData), .Stall(Stall), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_Be(Mem_Be), .Mem_WData(Mem_WData), .Mem_Ack(Mem_Ack),
        .Mem_RData(Mem_RData), .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite),
        .WB_MemtoReg(WB_MemtoReg), .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
        .WB_RegDstData(WB_RegDstData), .Br_Taken(Br_Taken), .Br_Target(Br_Target),
        .Align_Err(Align_Err), .Timeout_Err(Timeout_Err)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        aerr;
        logic        terr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] sx8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    task automatic drive(input logic rd_, input logic wr_, input logic [1:0] dt,
                         input logic [31:0] addr, input logic [31:0] d2,
                         input logic rw, input logic m2r, input logic [4:0] rdst);
        In_Valid = 1'b1; MEM_MemRead = rd_; MEM_MemWrite = wr_; MEM_Datatype = dt;
        MEM_ALUResult = addr; MEM_Data2 = d2; MEM_RegWrite = rw; MEM_MemtoReg = m2r;
        MEM_RegDstData = rdst; MEM_Branch = 1'b0; MEM_Zero = 1'b0;
    endtask

    task automatic pop_wb(input string tag);
        exp_t e;
        chk({tag, ".wb_valid"}, 32'(WB_Valid), 32'd1);
        chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".regwrite"}, 32'(WB_RegWrite), 32'(e.rw));
            chk({tag, ".memtoreg"}, 32'(WB_MemtoReg), 32'(e.m2r));
            chk({tag, ".readdata"}, WB_ReadData, e.rdata);
            chk({tag, ".alu"}, WB_ALUResult, e.alu);
            chk({tag, ".rd"}, 32'(WB_RegDstData), 32'(e.rd));
            chk({tag, ".align_err"}, 32'(Align_Err), 32'(e.aerr));
            chk({tag, ".timeout_err"}, 32'(Timeout_Err), 32'(e.terr));
        end
    endtask

    // Called in the issue cycle just after the inputs were driven; acks on the ack_cyc-th WAIT cycle.
    task automatic mem_wait(input string tag, input int ack_cyc, input logic [31:0] rdata,
                            input logic we, input logic [29:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        #1;
        chk({tag, ".stall_issue"}, 32'(Stall), 32'd1);
        chk({tag, ".req_pre"}, 32'(Mem_Req), 32'd0);
        for (int i = 1; i <= ack_cyc; i++) begin
            tick();
            chk({tag, ".req"}, 32'(Mem_Req), 32'd1);
            chk({tag, ".we"}, 32'(Mem_We), 32'(we));
            chk({tag, ".addr"}, 32'(Mem_Addr), 32'(addr));
            chk({tag, ".be"}, 32'(Mem_Be), 32'(be));
            chk({tag, ".wdata"}, Mem_WData, wdata);
            chk({tag, ".wb_idle"}, 32'(WB_Valid), 32'd0);
            if (i == ack_cyc) begin
                Mem_Ack = 1'b1;
                Mem_RData = rdata;
            end
            #1;
            chk({tag, ".stall_wait"}, 32'(Stall), 32'(i != ack_cyc));
        end
        tick();
        Mem_Ack = 1'b0; Mem_RData = '0; In_Valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        chk({tag, ".req_post"}, 32'(Mem_Req), 32'd0);
        pop_wb(tag);
    endtask

    initial begin
        int n;
        bit got;
        logic [31:0] lw;
        Clr = 1'b0; In_Valid = 1'b0; MEM_RegWrite = 1'b0; MEM_MemtoReg = 1'b0;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Branch = 1'b0; MEM_Zero = 1'b0;
        MEM_Datatype = 2'b00; MEM_PCResult = '0; MEM_ALUResult = '0; MEM_Data2 = '0;
        MEM_RegDstData = '0; Mem_Ack = 1'b0; Mem_RData = '0;

        tick(); tick();
        chk("rst.stall", 32'(Stall), 32'd0);
        chk("rst.req", 32'(Mem_Req), 32'd0);
        chk("rst.wb_valid", 32'(WB_Valid), 32'd0);
        chk("rst.br_taken", 32'(Br_Taken), 32'd0);
        chk("rst.br_target", Br_Target, 32'd0);
        chk("rst.align_err", 32'(Align_Err), 32'd0);
        chk("rst.timeout_err", 32'(Timeout_Err), 32'd0);
        Clr = 1'b1;
        tick();

        drive(1, 0, 2'b00, 32'h100, 32'h0, 1, 1, 5'd5);
        sb.push_back('{1, 1, 32'hDEADBEEF, 32'h100, 5'd5, 0, 0});
        mem_wait("ld_w", 3, 32'hDEADBEEF, 0, 30'h40, 4'hF, 32'h0);

        drive(1, 0, 2'b10, 32'h103, 32'h0, 1, 1, 5'd6);
        sb.push_back('{1, 1, 32'hFFFFFF80, 32'h103, 5'd6, 0, 0});
        mem_wait("ld_b", 1, 32'h80FFFFFF, 0, 30'h40, 4'hF, 32'h0);

        drive(1, 0, 2'b11, 32'h103, 32'h0, 1, 1, 5'd6);
        sb.push_back('{1, 1, 32'h00000080, 32'h103, 5'd6, 0, 0});
        mem_wait("ld_bu", 2, 32'h80FFFFFF, 0, 30'h40, 4'hF, 32'h0);

        drive(0, 1, 2'b01, 32'h6, 32'h1234ABCD, 1, 0, 5'd3);
        sb.push_back('{0, 0, 32'h0, 32'h6, 5'd3, 0, 0});
        mem_wait("st_h", 2, 32'h0, 1, 30'h1, 4'b1100, 32'hABCDABCD);

        lw = 32'h8C7A5F31;
        for (int lane = 0; lane < 4; lane++) begin
            drive(0, 1, 2'b10, 32'h10 + 32'(lane), 32'h000000A5, 0, 0, 5'd0);
            sb.push_back('{0, 0, 32'h0, 32'h10 + 32'(lane), 5'd0, 0, 0});
            mem_wait("st_b", 1, 32'h0, 1, 30'h4, 4'(1 << lane), 32'hA5A5A5A5);
            drive(1, 0, 2'b10, 32'h20 + 32'(lane), 32'h0, 1, 1, 5'd9);
            sb.push_back('{1, 1, sx8(8'((lw >> (8 * lane)) & 32'hFF)), 32'h20 + 32'(lane), 5'd9, 0, 0});
            mem_wait("ld_lane", 1, lw, 0, 30'h8, 4'hF, 32'h0);
        end

        drive(1, 1, 2'b00, 32'h2, 32'h0, 1, 1, 5'd4);
        sb.push_back('{0, 1, 32'h0, 32'h2, 5'd4, 1, 0});
        #1;
        chk("mis.stall", 32'(Stall), 32'd0);
        tick();
        In_Valid = 1'b0;
        chk("mis.req", 32'(Mem_Req), 32'd0);
        pop_wb("mis");
        tick();
        chk("mis.pulse_end", 32'(Align_Err), 32'd0);
        chk("mis.req_after", 32'(Mem_Req), 32'd0);

        drive(1, 0, 2'b00, 32'h200, 32'h0, 1, 1, 5'd9);
        sb.push_back('{0, 1, 32'h0, 32'h200, 5'd9, 0, 1});
        n = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (WB_Valid) begin
                got = 1'b1;
                break;
            end
            if (Mem_Req) n++;
            #1;
            if (!Stall) In_Valid = 1'b0;
        end
        In_Valid = 1'b0;
        chk("tmo.seen", 32'(got), 32'd1);
        chk("tmo.wait_cycles", 32'(n), 32'd4);
        chk("tmo.req", 32'(Mem_Req), 32'd0);
        pop_wb("tmo");
        tick();
        chk("tmo.pulse_end", 32'(Timeout_Err), 32'd0);
        chk("tmo.no_reissue", 32'(Mem_Req), 32'd0);

        drive(0, 0, 2'b00, 32'h55, 32'h0, 1, 0, 5'd7);
        MEM_Branch = 1'b1; MEM_Zero = 1'b1; MEM_PCResult = 32'h400;
        sb.push_back('{1, 0, 32'h0, 32'h55, 5'd7, 0, 0});
        #1;
        chk("br.stall", 32'(Stall), 32'd0);
        tick();
        MEM_Zero = 1'b0; MEM_PCResult = 32'h404;
        chk("br.taken", 32'(Br_Taken), 32'd1);
        chk("br.target", Br_Target, 32'h400);
        pop_wb("br");
        sb.push_back('{1, 0, 32'h0, 32'h55, 5'd7, 0, 0});
        tick();
        In_Valid = 1'b0; MEM_Branch = 1'b0;
        chk("brn.taken", 32'(Br_Taken), 32'd0);
        chk("brn.target", Br_Target, 32'h404);
        pop_wb("brn");
        tick();
        chk("br.idle_taken", 32'(Br_Taken), 32'd0);
        chk("br.idle_wb", 32'(WB_Valid), 32'd0);

        drive(1, 0, 2'b00, 32'h300, 32'h0, 1, 1, 5'd2);
        tick();
        chk("clr.req_before", 32'(Mem_Req), 32'd1);
        Clr = 1'b0; In_Valid = 1'b0;
        tick();
        chk("clr.req", 32'(Mem_Req), 32'd0);
        chk("clr.stall", 32'(Stall), 32'd0);
        chk("clr.wb_valid", 32'(WB_Valid), 32'd0);
        chk("clr.br_target", Br_Target, 32'd0);
        chk("clr.addr", 32'(Mem_Addr), 32'd0);
        chk("clr.wb_alu", WB_ALUResult, 32'd0);
        Clr = 1'b1; Mem_Ack = 1'b1; Mem_RData = 32'hCAFEF00D;
        tick();
        Mem_Ack = 1'b0;
        chk("late_ack.wb_valid", 32'(WB_Valid), 32'd0);
        chk("late_ack.req", 32'(Mem_Req), 32'd0);
        tick();
        chk("late_ack.wb_valid2", 32'(WB_Valid), 32'd0);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
